// File: rtl/alu_slice_seq_pkg.sv
// Shared definitions for the HC4e multi-cycle slice ALU: op-code and FSM state encodings.
// The op codes are also used by the datapath decoder, so keep this encoding stable.
package alu_slice_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_ADD  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SUB  = 3'b101,
        OP_THRU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Only ADD and SUB produce a meaningful signed overflow.
    function automatic logic is_arith(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational W-bit ALU slice: forms the per-op operand pair and adds the chained carry.
// Undefined op codes give zero result, zero carry and raise illegal.
module alu_slice
    import alu_slice_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         illegal
);

    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [W:0]   sum;

    // Every op is "something + carry"; logic ops just leave rhs at zero.
    always_comb begin
        lhs     = '0;
        rhs     = '0;
        illegal = 1'b0;
        case (sel)
            OP_ADD:  begin lhs = a; rhs = b;  end
            OP_SUB:  begin lhs = a; rhs = ~b; end
            OP_XOR:  lhs = a ^ b;
            OP_THRU: lhs = a;
            OP_AND:  lhs = a & b;
            OP_OR:   lhs = a | b;
            default: illegal = 1'b1;
        endcase
        sum = {1'b0, lhs} + {1'b0, rhs} + {{W{1'b0}}, cin & ~illegal};
    end

    assign y    = sum[W-1:0];
    assign cout = sum[W];

endmodule

// File: rtl/alu_slice_seq.sv
// Multi-cycle DATA_W-bit ALU built from one SLICE_W-bit slice, LS slice first, start/busy/done handshake.
// Define ALU_OVF_EN to add the registered signed-overflow output ovf_out for ADD/SUB.
module alu_slice_seq
    import alu_slice_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        sel_in,
    input  logic [DATA_W-1:0] in_A,
    input  logic [DATA_W-1:0] in_B,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out,
    output logic              carry_out,
    output logic              zero_out,
`ifdef ALU_OVF_EN
    output logic              ovf_out,
`endif
    output logic              illegal
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    alu_state_e        state;
    logic [CNT_W-1:0]  slice_cnt;
    logic [2:0]        op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              carry_reg;

    logic [SLICE_W-1:0] slice_y;
    logic               slice_cout;
    logic               slice_illegal;
    logic [DATA_W-1:0]  next_out;

    // Operands are shifted right each cycle so the slice always sees their low bits.
    alu_slice #(.W(SLICE_W)) u_slice (
        .sel     (op_reg),
        .a       (a_reg[SLICE_W-1:0]),
        .b       (b_reg[SLICE_W-1:0]),
        .cin     (carry_reg),
        .y       (slice_y),
        .cout    (slice_cout),
        .illegal (slice_illegal)
    );

    always_comb begin
        next_out = out;
        next_out[int'(slice_cnt)*SLICE_W +: SLICE_W] = slice_y;
    end

`ifdef ALU_OVF_EN
    logic b_msb;
    logic msb_carry_in;
    logic slice_ovf;

    // Carry into the MSB is recovered from the MSB sum bit of the top slice.
    always_comb begin
        b_msb        = (op_reg == OP_SUB) ? ~b_reg[SLICE_W-1] : b_reg[SLICE_W-1];
        msb_carry_in = a_reg[SLICE_W-1] ^ b_msb ^ slice_y[SLICE_W-1];
        slice_ovf    = is_arith(op_reg) & (msb_carry_in ^ slice_cout);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slice_cnt <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_out   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg    <= sel_in;
                        a_reg     <= in_A;
                        b_reg     <= in_B;
                        carry_reg <= carry_in;
                        slice_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    out       <= next_out;
                    a_reg     <= a_reg >> SLICE_W;
                    b_reg     <= b_reg >> SLICE_W;
                    carry_reg <= slice_cout;
                    if (slice_cnt == LAST_SLICE) begin
                        // Flags change only here, together with the done pulse.
                        slice_cnt <= '0;
                        done      <= 1'b1;
                        carry_out <= slice_cout;
                        zero_out  <= (next_out == '0);
                        illegal   <= slice_illegal;
`ifdef ALU_OVF_EN
                        ovf_out   <= slice_ovf;
`endif
                        state     <= ST_DONE;
                    end else begin
                        slice_cnt <= slice_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed scoreboard bench for alu_slice_seq; expected results come from a full-width reference model.
// Define ALU_OVF_EN to also exercise ovf_out.
module tb_alu_slice_seq;

    localparam int DATA_W  = 16;
    localparam int SLICE_W = 4;
    localparam int NSLICE  = DATA_W / SLICE_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [2:0]        sel_in;
    logic [DATA_W-1:0] in_A;
    logic [DATA_W-1:0] in_B;
    logic              carry_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out;
    logic              carry_out;
    logic              zero_out;
    logic              illegal;
`ifdef ALU_OVF_EN
    logic              ovf_out;
`endif

    typedef struct {
        logic [15:0] out;
        logic        carry;
        logic        zero;
        logic        illegal;
        logic        ovf;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_slice_seq #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel_in    (sel_in),
        .in_A      (in_A),
        .in_B      (in_B),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .carry_out (carry_out),
        .zero_out  (zero_out),
`ifdef ALU_OVF_EN
        .ovf_out   (ovf_out),
`endif
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] s, input logic [15:0] a,
                                   input logic [15:0] b, input logic c);
        exp_t        e;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic [16:0] sum;
        lhs = 16'h0;
        rhs = 16'h0;
        e.illegal = 1'b0;
        case (s)
            3'b011: begin lhs = a; rhs = b;  end
            3'b101: begin lhs = a; rhs = ~b; end
            3'b100: lhs = a ^ b;
            3'b111: lhs = a;
            3'b001: lhs = a & b;
            3'b010: lhs = a | b;
            default: e.illegal = 1'b1;
        endcase
        sum     = {1'b0, lhs} + {1'b0, rhs} + {16'h0, c & ~e.illegal};
        e.out   = sum[15:0];
        e.carry = sum[16];
        e.zero  = (sum[15:0] == 16'h0);
        e.ovf   = ((s == 3'b011) || (s == 3'b101)) &&
                  (lhs[15] == rhs[15]) && (sum[15] != lhs[15]);
        e.tag   = "";
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checkValue("sb_depth", 16'(sb.size()), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkValue({e.tag, ":out"},     out,                e.out);
            checkValue({e.tag, ":carry"},   16'(carry_out),     16'(e.carry));
            checkValue({e.tag, ":zero"},    16'(zero_out),      16'(e.zero));
            checkValue({e.tag, ":illegal"}, 16'(illegal),       16'(e.illegal));
`ifdef ALU_OVF_EN
            checkValue({e.tag, ":ovf"},     16'(ovf_out),       16'(e.ovf));
`endif
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after an edge, DUT idle.
    task automatic applyStimulus(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input string tag, input bit disturb);
        exp_t e;
        int   cycles;
        int   pulses;
        e     = model(s, a, b, c);
        e.tag = tag;
        sb.push_back(e);
        sel_in   = s;
        in_A     = a;
        in_B     = b;
        carry_in = c;
        start    = 1'b1;
        @(posedge clk); #1;
        start = disturb;
        if (disturb) begin
            sel_in   = 3'b110;
            in_A     = ~a;
            in_B     = 16'h5555;
            carry_in = ~c;
        end
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        checkValue({tag, ":latency"}, 16'(cycles), 16'(NSLICE));
        checkValue({tag, ":busy_at_done"}, 16'(busy), 16'd1);
        checkOutput();
        @(posedge clk); #1;
        checkValue({tag, ":done_pulse_end"}, 16'(done), 16'd0);
        checkValue({tag, ":busy_end"}, 16'(busy), 16'd0);
        if (disturb) begin
            pulses = 0;
            repeat (NSLICE + 3) begin
                @(posedge clk); #1;
                pulses += int'(done);
            end
            checkValue({tag, ":extra_done"}, 16'(pulses), 16'd0);
            checkValue({tag, ":out_held"}, out, e.out);
        end
    endtask

    logic [2:0] legal_ops [6];

    initial begin
        int pulses;
        legal_ops = '{3'b011, 3'b100, 3'b111, 3'b001, 3'b010, 3'b101};
        rst_n    = 1'b0;
        start    = 1'b0;
        sel_in   = 3'b000;
        in_A     = 16'h0;
        in_B     = 16'h0;
        carry_in = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkValue("rst:busy",      16'(busy),      16'd0);
        checkValue("rst:done",      16'(done),      16'd0);
        checkValue("rst:out",       out,            16'h0);
        checkValue("rst:carry",     16'(carry_out), 16'd0);
        checkValue("rst:zero",      16'(zero_out),  16'd0);
        checkValue("rst:illegal",   16'(illegal),   16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkValue("post_rst:busy", 16'(busy),      16'd0);

        applyStimulus(3'b011, 16'hFFFF, 16'h0001, 1'b0, "add_wrap",   1'b0);
        applyStimulus(3'b101, 16'h1234, 16'h0235, 1'b1, "sub_noborr", 1'b0);
        applyStimulus(3'b101, 16'h0001, 16'h0002, 1'b1, "sub_borrow", 1'b0);
        applyStimulus(3'b100, 16'hA5A5, 16'h5A5A, 1'b0, "xor",        1'b0);
        applyStimulus(3'b111, 16'h00FF, 16'h1234, 1'b1, "thru_cin",   1'b0);
        applyStimulus(3'b001, 16'hF0F0, 16'h3C3C, 1'b0, "and",        1'b0);
        applyStimulus(3'b010, 16'h0F00, 16'h00F0, 1'b1, "or_cin",     1'b0);
        applyStimulus(3'b110, 16'hFFFF, 16'hFFFF, 1'b1, "illegal110", 1'b0);
        applyStimulus(3'b000, 16'h1234, 16'h4321, 1'b0, "illegal000", 1'b0);
        applyStimulus(3'b011, 16'h1111, 16'h2222, 1'b1, "add_clrill", 1'b0);
        applyStimulus(3'b011, 16'h0F0F, 16'h0101, 1'b0, "ignore_2nd", 1'b1);
`ifdef ALU_OVF_EN
        applyStimulus(3'b011, 16'h7FFF, 16'h0001, 1'b0, "add_ovf",    1'b0);
        applyStimulus(3'b101, 16'h8000, 16'h0001, 1'b1, "sub_ovf",    1'b0);
        applyStimulus(3'b011, 16'h7FFE, 16'h0001, 1'b0, "add_no_ovf", 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            applyStimulus(legal_ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", i), 1'b0);
        end

        // Abort a running operation with reset: everything clears, no done follows.
        sel_in   = 3'b111;
        in_A     = 16'hFFFF;
        in_B     = 16'h0000;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkValue("abort:busy", 16'(busy), 16'd0);
        checkValue("abort:done", 16'(done), 16'd0);
        checkValue("abort:out",  out,       16'h0);
        checkValue("abort:zero", 16'(zero_out), 16'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (NSLICE + 4) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        checkValue("abort:no_done", 16'(pulses), 16'd0);
        checkValue("abort:idle",    16'(busy),   16'd0);

        applyStimulus(3'b011, 16'h0002, 16'h0003, 1'b0, "after_abort", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
